// File: rtl/add_reg_pkg.sv
// add_reg_pkg: shared FSM state, op encodings and default sizes for add_reg_arbiter.
package add_reg_pkg;
    typedef enum logic [1:0] {IDLE, CLEAR, EXEC, RESP} state_t;
    localparam logic OP_LOAD = 1'b0;
    localparam logic OP_ACCUM = 1'b1;
    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DATA_W = 8;
endpackage

// File: rtl/add_reg_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick starting at rr_ptr; the pointer lives in the parent.
module rr_arbiter
    import add_reg_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               any_grant
);
    logic [ID_W-1:0] j;
    always_comb begin
        j = '0;
        grant_idx = '0;
        // Walk backwards so the candidate closest to rr_ptr is written last and wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (req[j]) grant_idx = j;
        end
        any_grant = |req;
        grant = any_grant ? NUM_REQ'(1) << grant_idx : '0;
    end
endmodule

// File: rtl/add_reg_arbiter.sv
// add_reg_arbiter: round-robin sharing of one external add-and-store register among NUM_REQ requesters.
module add_reg_arbiter
    import add_reg_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ID_W = 2,
    parameter int RSP_TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_op,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic                      clr,
    output logic [DATA_W-1:0]         reg_d,
    output logic                      reg_en,
    input  logic [DATA_W-1:0]         reg_q,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_carry,
    output logic                      rsp_drop
);
    state_t state, state_nx;
    logic [ID_W-1:0] rr_ptr, cap_id, gnt_idx;
    logic [NUM_REQ-1:0] gnt;
    logic any_gnt, clr_pend, cap_op, cap_carry, take, timeout;
    logic [DATA_W-1:0] cap_a, cap_b;
    logic [7:0] wait_cnt;
    logic [DATA_W:0] sum;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req(req_valid),
        .rr_ptr(rr_ptr),
        .grant(gnt),
        .grant_idx(gnt_idx),
        .any_grant(any_gnt)
    );

    always_comb begin
        sum = (cap_op == OP_ACCUM) ? {1'b0, reg_q} + {1'b0, cap_a} : {1'b0, cap_a} + {1'b0, cap_b};
        timeout = wait_cnt == 8'(RSP_TIMEOUT - 1);
        take = state == IDLE && !clr && !clr_pend && any_gnt;
        state_nx = state;
        case (state)
            IDLE:    state_nx = (clr || clr_pend) ? CLEAR : any_gnt ? EXEC : IDLE;
            CLEAR:   state_nx = IDLE;
            EXEC:    state_nx = RESP;
            RESP:    state_nx = (rsp_ready || timeout) ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
        // Grant is gated by rst_n so every output reads 0 while reset is held.
        req_ready = (take && rst_n) ? gnt : '0;
        reg_en = state == CLEAR || state == EXEC;
        reg_d = (state == EXEC) ? sum[DATA_W-1:0] : '0;
        rsp_valid = state == RESP;
        rsp_id = rsp_valid ? cap_id : '0;
        rsp_data = rsp_valid ? reg_q : '0;
        rsp_carry = rsp_valid ? cap_carry : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rr_ptr <= '0;
            clr_pend <= 1'b0;
            cap_id <= '0;
            cap_op <= OP_LOAD;
            cap_a <= '0;
            cap_b <= '0;
            cap_carry <= 1'b0;
            wait_cnt <= '0;
            rsp_drop <= 1'b0;
        end else begin
            state <= state_nx;
            // A clr seen during CLEAR is satisfied by the zeroing write on that same edge.
            clr_pend <= (state == CLEAR) ? 1'b0 : (clr && state != IDLE) ? 1'b1 : clr_pend;
            wait_cnt <= (state == RESP) ? wait_cnt + 8'd1 : 8'd0;
            rsp_drop <= state == RESP && !rsp_ready && timeout;
            if (state == EXEC) cap_carry <= sum[DATA_W];
            if (take) begin
                cap_id <= gnt_idx;
                cap_op <= req_op[gnt_idx];
                cap_a <= req_a[gnt_idx*DATA_W +: DATA_W];
                cap_b <= req_b[gnt_idx*DATA_W +: DATA_W];
                rr_ptr <= ID_W'((int'(gnt_idx) + 1) % NUM_REQ);
            end
        end
    end
endmodule

// File: tb/tb_add_reg_arbiter.sv
// tb_add_reg_arbiter: directed plus random stimulus, transaction-level model and response scoreboard.
module tb_add_reg_arbiter;
    import add_reg_pkg::*;
    localparam int N = 4;
    localparam int W = 8;
    localparam int T = 15;

    logic clk = 0, rst_n = 0, clr = 0, rsp_ready = 0;
    logic [N-1:0] req_valid = '0, req_op = '0, req_ready;
    logic [N*W-1:0] req_a = '0, req_b = '0;
    logic [W-1:0] reg_d, rsp_data, reg_q = '0;
    logic reg_en, rsp_valid, rsp_carry, rsp_drop;
    logic [1:0] rsp_id;

    typedef struct packed {logic [1:0] id; logic [7:0] data; logic carry;} rsp_t;
    rsp_t sb[$];
    int gcyc[$];
    int tests = 0, fails = 0, cyc = 0, vcnt = 0, model_ptr = 0;
    int model_reg = 0, exp_d = 0;
    bit pend_clr = 0, exec_due = 0;

    add_reg_arbiter #(.NUM_REQ(N), .DATA_W(W), .ID_W(2), .RSP_TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .clr(clr),
        .reg_d(reg_d), .reg_en(reg_en), .reg_q(reg_q),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_drop(rsp_drop)
    );

    always #5 clk = ~clk;
    // The shared register itself lives outside the DUT and is untouched by reset.
    always @(posedge clk) if (reg_en) reg_q <= reg_d;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_req(int i, logic op, logic [7:0] a, logic [7:0] b);
        req_valid[i] = 1'b1;
        req_op[i] = op;
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic wait_ready(int i);
        bit got = 0;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge clk);
            got = req_ready[i];
        end
        check($sformatf("grant_seen%0d", i), 32'(got), 32'd1);
        @(posedge clk);
        #1 req_valid[i] = 1'b0;
    endtask

    task automatic do_req(int i, logic op, logic [7:0] a, logic [7:0] b);
        @(posedge clk);
        #1 set_req(i, op, a, b);
        wait_ready(i);
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pop_check(bit dropped);
        rsp_t r;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL sb_pop: got a response with nothing outstanding, expected none");
        end else begin
            r = sb.pop_front();
            if (!dropped) begin
                check("rsp_id", 32'(rsp_id), 32'(r.id));
                check("rsp_data", 32'(rsp_data), 32'(r.data));
                check("rsp_carry", 32'(rsp_carry), 32'(r.carry));
            end
        end
    endtask

    // Monitor: transaction-level model of grants and register contents, plus response checking.
    always @(negedge clk) if (rst_n) begin
        int e, gi, s;
        rsp_t r;
        cyc++;
        check("onehot", 32'($countones(req_ready) <= 1), 32'd1);
        check("ready_wo_valid", 32'(req_ready & ~req_valid), 32'd0);
        if (exec_due) begin
            check("exec_en", 32'(reg_en), 32'd1);
            check("exec_d", 32'(reg_d), 32'(exp_d));
            exec_due = 0;
        end else if (reg_en) check("clear_d", 32'(reg_d), 32'd0);
        if (req_ready != '0) begin
            check("grant_on_clr", 32'(clr), 32'd0);
            e = -1;
            gi = -1;
            for (int k = N - 1; k >= 0; k--) if (req_valid[(model_ptr + k) % N]) e = (model_ptr + k) % N;
            for (int k = 0; k < N; k++) if (req_ready[k]) gi = k;
            check("grant_idx", 32'(gi), 32'(e));
            if (gcyc.size() > 0) check("grant_gap", 32'(cyc - gcyc[$] >= 3), 32'd1);
            gcyc.push_back(cyc);
            if (pend_clr) model_reg = 0;
            pend_clr = 0;
            s = req_op[gi] ? model_reg + int'(req_a[gi*W +: W]) : int'(req_a[gi*W +: W]) + int'(req_b[gi*W +: W]);
            r.id = 2'(gi);
            r.data = 8'(s % 256);
            r.carry = s > 255;
            sb.push_back(r);
            model_reg = s % 256;
            exp_d = s % 256;
            exec_due = 1;
            model_ptr = (gi + 1) % N;
        end
        if (clr) pend_clr = 1;
        if (rsp_valid) begin
            vcnt++;
            if (vcnt == 1 && gcyc.size() > 0) check("rsp_latency", 32'(cyc - gcyc[$]), 32'd2);
            if (rsp_ready) begin
                pop_check(0);
                vcnt = 0;
            end
        end
        if (rsp_drop) begin
            check("drop_len", 32'(vcnt), 32'(T));
            check("drop_valid", 32'(rsp_valid), 32'd0);
            pop_check(1);
            vcnt = 0;
        end
    end

    initial begin
        int base, mode;
        bit got;
        logic [N-1:0] g;
        req_valid = '1;
        repeat (3) @(posedge clk);
        #1 check("reset_outs", 32'({req_ready, reg_en, reg_d, rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_drop}), 32'd0);
        req_valid = '0;
        @(negedge clk) rst_n = 1;
        rsp_ready = 1;
        do_req(0, OP_LOAD, 8'h12, 8'h34);
        idle(4);
        do_req(1, OP_LOAD, 8'h70, 8'h80);
        idle(4);
        do_req(2, OP_ACCUM, 8'h20, 8'h55);
        idle(4);
        rsp_ready = 0;
        do_req(3, OP_LOAD, 8'h01, 8'h02);
        idle(20);
        rsp_ready = 1;
        do_req(0, OP_ACCUM, 8'h01, 8'h00);
        idle(4);
        // All requesters valid back to back: rotation and one grant every 3 cycles.
        base = gcyc.size();
        for (int i = 0; i < N; i++) set_req(i, OP_LOAD, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        for (int n = 0; n < 40 && gcyc.size() < base + 5; n++) @(negedge clk);
        @(posedge clk);
        #1 req_valid = '0;
        check("rr_grants", 32'(gcyc.size() >= base + 5), 32'd1);
        if (gcyc.size() >= base + 5)
            for (int k = 1; k < 5; k++) check("rr_gap", 32'(gcyc[base+k] - gcyc[base+k-1]), 32'd3);
        idle(5);
        // clr during EXEC is serviced before the waiting ACCUM, which therefore starts from 0.
        do_req(0, OP_LOAD, 8'h05, 8'h06);
        clr = 1;
        set_req(1, OP_ACCUM, 8'h07, 8'h00);
        @(posedge clk);
        #1 clr = 0;
        wait_ready(1);
        idle(5);
        // Reset in RESP: response abandoned, pointer back to 0.
        rsp_ready = 0;
        do_req(2, OP_LOAD, 8'h09, 8'h09);
        got = 0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            got = rsp_valid;
        end
        check("rsp_before_reset", 32'(got), 32'd1);
        #2 rst_n = 0;
        #1 check("midreset_outs", 32'({req_ready, reg_en, reg_d, rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_drop}), 32'd0);
        sb.delete();
        model_ptr = 0;
        pend_clr = 0;
        exec_due = 0;
        vcnt = 0;
        @(posedge clk);
        #2 rst_n = 1;
        rsp_ready = 1;
        set_req(3, OP_LOAD, 8'h02, 8'h02);
        set_req(0, OP_LOAD, 8'h01, 8'h01);
        wait_ready(0);
        wait_ready(3);
        idle(5);
        mode = 2;
        for (int c = 0; c < 3000; c++) begin
            if (c % 32 == 0) mode = int'($urandom_range(0, 3));
            @(negedge clk);
            g = req_ready;
            @(posedge clk);
            #1;
            rsp_ready = mode == 0 ? 1'b0 : mode == 1 ? 1'($urandom_range(0, 1)) : 1'b1;
            clr = $urandom_range(0, 49) == 0;
            for (int i = 0; i < N; i++) begin
                if (g[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(0, 3) == 0)
                    set_req(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
                else if (req_valid[i] && !g[i] && $urandom_range(0, 31) == 0)
                    req_valid[i] = 1'b0;
            end
        end
        clr = 0;
        req_valid = '0;
        rsp_ready = 1;
        idle(30);
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
